uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLOCKS_PER_BAUD, default 10: clk cycles per bit period; SHALL be supported for values >= 4.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, LSB first; SHALL be supported for 5..9.
REQ-003 Parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1: SHALL be supported for 1 or 2.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1: sole clock.
REQ-007 Port rst, input, 1: synchronous active-high reset.
REQ-008 Port rx, input, 1: asynchronous serial line, idle high.
REQ-009 Port data_o, output, DATA_BITS: last received data word.
REQ-010 Port valid_o, output, 1: one-cycle pulse when a frame completes.
REQ-011 Port parity_err_o, output, 1: parity check failed for the frame flagged by valid_o.
REQ-012 Port framing_err_o, output, 1: a stop bit was sampled low in the frame flagged by valid_o.
REQ-013 Port busy_o, output, 1: high in every state except IDLE.

Function
REQ-014 rx SHALL pass through a two-flop synchronizer; all logic SHALL use only the synchronized value (rx_s).
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-016 IDLE: a cycle with rx_s = 0 SHALL move to START and clear the baud counter.
REQ-017 START: at CLOCKS_PER_BAUD/2 (integer division) cycles after entry, sample rx_s; 0 -> DATA; 1 -> IDLE (glitch rejected, no valid_o).
REQ-018 DATA: sample every CLOCKS_PER_BAUD cycles after the start-bit midpoint sample, shifting in LSB first; after DATA_BITS samples -> PARITY if PARITY != 0, else STOP.
REQ-019 PARITY: sample one bit; parity error = XOR of data bits and parity bit is 0 (odd mode) or 1 (even mode).
REQ-020 STOP: sample STOP_BITS bits at bit-period spacing; any low sample sets the framing flag.
REQ-021 On the cycle after the final stop sample: valid_o = 1 for exactly one cycle; data_o, parity_err_o and framing_err_o updated in that same cycle.
REQ-022 After the final stop sample: rx_s = 1 -> IDLE immediately (back-to-back frames SHALL be received with zero idle bits); rx_s = 0 -> WAIT_IDLE.
REQ-023 WAIT_IDLE: remain until rx_s = 1, then -> IDLE; a held-low line (break) SHALL produce no further valid_o pulses.
REQ-024 data_o, parity_err_o and framing_err_o SHALL hold their values between valid_o pulses.
REQ-025 parity_err_o SHALL be 0 whenever PARITY = 0.
REQ-026 Baud counter width SHALL be $clog2(CLOCKS_PER_BAUD); the counter SHALL reload at bit-period boundaries with no accumulated drift.
REQ-027 Total latency from the rx falling edge at the pin to valid_o SHALL be 2 + CLOCKS_PER_BAUD/2 + (DATA_BITS + P + STOP_BITS)*CLOCKS_PER_BAUD + 1 cycles, where P = 1 if PARITY != 0, else 0.

Reset
REQ-028 While rst = 1, the FSM SHALL enter IDLE and clear the counters and shift register; data_o = 0, valid_o = 0, parity_err_o = 0, framing_err_o = 0, busy_o = 0; synchronizer flops SHALL be set to 1.
REQ-029 rst asserted mid-frame SHALL abort the frame with no valid_o pulse; reception SHALL restart only on a new falling edge after rst is released.

Verification
REQ-030 Defaults; all 256 bytes sent with 100-cycle gaps -> exactly one valid_o per byte, data_o matches, both error flags 0, valid_o never high before the stop bit.
REQ-031 Defaults; all 256 bytes sent back-to-back -> 256 valid_o pulses, correct data, none dropped.
REQ-032 PARITY=2, DATA_BITS=7, STOP_BITS=2; send 0x55 with correct then inverted parity bit -> parity_err_o = 0, then 1; data_o = 0x55 both times.
REQ-033 Defaults; send 0xA5 with stop bit low, line then held low for 30 bit periods -> one valid_o with framing_err_o = 1, no further pulses; next good frame after the line returns high is received correctly.
REQ-034 Defaults; rx low pulse of 3 cycles -> no valid_o, busy_o returns to 0 within CLOCKS_PER_BAUD cycles.
REQ-035 Defaults; rst pulsed during data bit 4 of a frame -> no valid_o for that frame, all outputs at reset values, next frame is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// optional odd/even parity and 1 or 2 stop bits, registered result with a one-cycle valid pulse.
module uart_rx_cfg #(
    parameter int CLOCKS_PER_BAUD = 10,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 parity_err_o,
    output logic                 framing_err_o,
    output logic                 busy_o
);

    // state       | meaning
    // S_IDLE      | line idle, waiting for a low level on rx_s
    // S_START     | timing to the start-bit midpoint, rejecting glitches
    // S_DATA      | sampling data bits, LSB first
    // S_PARITY    | sampling the parity bit
    // S_STOP      | sampling stop bit(s); result is published on the last one
    // S_WAIT_IDLE | line stuck low after a bad stop bit, waiting for it to go high

    localparam int              CW      = $clog2(CLOCKS_PER_BAUD);
    localparam int              BW      = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0]   HALF_TC = CW'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [CW-1:0]   BIT_TC  = CW'(CLOCKS_PER_BAUD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t               state, state_nx;
    logic                 rx_meta, rx_s;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 stop_low;
    logic                 tick;
    logic                 frame_done;
    logic                 par_err_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        frame_done = 1'b0;
        busy_o     = (state != S_IDLE);
        // the first sample lands half a bit in; every later sample is a full bit apart
        tick       = (state == S_START) ? (baud_cnt == HALF_TC) : (baud_cnt == BIT_TC);
        case (state)
            S_IDLE: begin
                if (!rx_s) state_nx = S_START;
            end
            S_START: begin
                if (tick) state_nx = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (tick && bit_cnt == BW'(DATA_BITS - 1))
                    state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (tick) state_nx = S_STOP;
            end
            S_STOP: begin
                if (tick && bit_cnt == BW'(STOP_BITS - 1)) begin
                    frame_done = 1'b1;
                    state_nx   = rx_s ? S_IDLE : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        par_err_nx = 1'b0;
        if (PARITY == 1)      par_err_nx = ~((^shreg) ^ par_bit);
        else if (PARITY == 2) par_err_nx = (^shreg) ^ par_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            par_bit       <= 1'b0;
            stop_low      <= 1'b0;
            data_o        <= '0;
            valid_o       <= 1'b0;
            parity_err_o  <= 1'b0;
            framing_err_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            // reload on every sample point so bit timing never drifts
            if (state == S_IDLE || tick) baud_cnt <= '0;
            else                         baud_cnt <= baud_cnt + 1'b1;
            if (state_nx != state) bit_cnt <= '0;
            else if (tick)         bit_cnt <= bit_cnt + 1'b1;
            if (state == S_DATA && tick)   shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            if (state == S_PARITY && tick) par_bit <= rx_s;
            if (state == S_START)                      stop_low <= 1'b0;
            else if (state == S_STOP && tick && !rx_s) stop_low <= 1'b1;
            if (frame_done) begin
                valid_o       <= 1'b1;
                data_o        <= shreg;
                parity_err_o  <= par_err_nx;
                framing_err_o <= stop_low | ~rx_s;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: a default 8N1 instance and a 7E2 instance, checked by a
// scoreboard that predicts data, error flags and the exact valid_o cycle for each frame.
module tb_uart_rx_cfg;

    localparam int CPB0 = 10;
    localparam int CPB1 = 6;
    localparam int DB1  = 7;
    localparam int L0   = 2 + CPB0 / 2 + (8 + 0 + 1) * CPB0 + 1;
    localparam int L1   = 2 + CPB1 / 2 + (DB1 + 1 + 2) * CPB1 + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx0, rx1;
    logic [7:0] data0;
    logic [6:0] data1;
    logic       valid0, perr0, ferr0, busy0;
    logic       valid1, perr1, ferr1, busy1;
    int         cyc = 0;

    typedef struct {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        int         at;
    } exp_t;

    typedef struct {
        logic [6:0] d;
        logic       pflip;
        logic [1:0] smask;
        logic       epe;
        logic       efe;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;

    uart_rx_cfg dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .data_o(data0), .valid_o(valid0),
        .parity_err_o(perr0), .framing_err_o(ferr0), .busy_o(busy0)
    );

    uart_rx_cfg #(.CLOCKS_PER_BAUD(CPB1), .DATA_BITS(DB1), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .data_o(data1), .valid_o(valid1),
        .parity_err_o(perr1), .framing_err_o(ferr1), .busy_o(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid0) begin
                if (q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL d0_unexpected_valid got=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    e = q0.pop_front();
                    chk("d0_data", 32'(data0), 32'(e.data));
                    chk("d0_parity_err", 32'(perr0), 32'(e.pe));
                    chk("d0_framing_err", 32'(ferr0), 32'(e.fe));
                    chk("d0_latency", 32'(cyc), 32'(e.at));
                end
            end
            if (valid1) begin
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL d1_unexpected_valid got=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    e = q1.pop_front();
                    chk("d1_data", 32'(data1), 32'(e.data));
                    chk("d1_parity_err", 32'(perr1), 32'(e.pe));
                    chk("d1_framing_err", 32'(ferr1), 32'(e.fe));
                    chk("d1_latency", 32'(cyc), 32'(e.at));
                end
            end
        end
    endtask

    task automatic bit0(input logic b);
        rx0 = b;
        repeat (CPB0) @(negedge clk);
    endtask

    task automatic bit1(input logic b);
        rx1 = b;
        repeat (CPB1) @(negedge clk);
    endtask

    task automatic send0(input logic [7:0] d, input logic stop, input logic after, input int gap);
        exp_t e;
        e.data = {1'b0, d};
        e.pe   = 1'b0;
        e.fe   = ~stop;
        e.at   = cyc + L0;
        q0.push_back(e);
        bit0(1'b0);
        for (int i = 0; i < 8; i++) bit0(d[i]);
        bit0(stop);
        rx0 = after;
        repeat (gap) @(negedge clk);
    endtask

    // parity bit on the wire is the even-parity value, optionally inverted
    task automatic send1(input logic [6:0] d, input logic pflip, input logic [1:0] smask,
                         input int gap, input logic epe, input logic efe);
        exp_t e;
        e.data = {2'b00, d};
        e.pe   = epe;
        e.fe   = efe;
        e.at   = cyc + L1;
        q1.push_back(e);
        bit1(1'b0);
        for (int i = 0; i < DB1; i++) bit1(d[i]);
        bit1((^d) ^ pflip);
        bit1(smask[0]);
        bit1(smask[1]);
        rx1 = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_pending0"}, 32'(q0.size()), 32'd0);
        chk({name, "_pending1"}, 32'(q1.size()), 32'd0);
    endtask

    initial begin
        vec_t       tbl[6];
        int         perm[256];
        int         j, tmp, ones, n, gap;
        logic [6:0] d;
        logic       pflip, s1, pbit;

        tbl[0] = '{7'h55, 1'b0, 2'b11, 1'b0, 1'b0};
        tbl[1] = '{7'h55, 1'b1, 2'b11, 1'b1, 1'b0};
        tbl[2] = '{7'h7F, 1'b0, 2'b11, 1'b0, 1'b0};
        tbl[3] = '{7'h00, 1'b1, 2'b11, 1'b1, 1'b0};
        tbl[4] = '{7'h2A, 1'b0, 2'b10, 1'b0, 1'b1};
        tbl[5] = '{7'h01, 1'b1, 2'b01, 1'b1, 1'b1};

        rst = 1'b1;
        rx0 = 1'b1;
        rx1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data0", 32'(data0), 32'd0);
        chk("rst_valid0", 32'(valid0), 32'd0);
        chk("rst_perr0", 32'(perr0), 32'd0);
        chk("rst_ferr0", 32'(ferr0), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        fork
            monitor();
        join_none

        // every byte in order, 100-cycle idle gaps
        for (int i = 0; i < 256; i++) send0(8'(i), 1'b1, 1'b1, 100);
        drain("gapped");

        // every byte back-to-back in shuffled order
        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            j       = int'($urandom_range(i, 0));
            tmp     = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        for (int i = 0; i < 256; i++) send0(8'(perm[i]), 1'b1, 1'b1, 0);
        drain("b2b");

        // 7E2 table vectors
        for (int i = 0; i < 6; i++)
            send1(tbl[i].d, tbl[i].pflip, tbl[i].smask, 10, tbl[i].epe, tbl[i].efe);
        drain("table");

        // 7E2 random frames: random data, parity corruption, first-stop corruption, gaps
        for (int k = 0; k < 24; k++) begin
            d     = 7'($urandom);
            pflip = 1'($urandom_range(1, 0));
            s1    = 1'($urandom_range(1, 0));
            gap   = int'($urandom_range(15, 0));
            ones  = 0;
            for (int b = 0; b < DB1; b++) if (d[b]) ones++;
            pbit  = 1'(ones % 2) ^ pflip;
            send1(d, pflip, {1'b1, s1}, gap, 1'((ones + int'(pbit)) % 2), ~s1);
        end
        drain("random");

        // bad stop bit followed by a 30-bit-period break, then a good frame
        send0(8'hA5, 1'b0, 1'b0, 300);
        chk("break_busy", 32'(busy0), 32'd1);
        rx0 = 1'b1;
        repeat (20) @(negedge clk);
        chk("break_release_busy", 32'(busy0), 32'd0);
        send0(8'h3C, 1'b1, 1'b1, 20);
        drain("break");

        // 3-cycle glitch must be rejected
        rx0 = 1'b0;
        repeat (3) @(negedge clk);
        rx0 = 1'b1;
        chk("glitch_busy_set", 32'(busy0), 32'd1);
        n = 0;
        while (busy0 && n < CPB0) begin
            @(negedge clk);
            n++;
        end
        chk("glitch_busy_clear", 32'(busy0), 32'd0);
        repeat (20) @(negedge clk);
        drain("glitch");

        // reset in the middle of data bit 4 aborts the frame
        bit0(1'b0);
        for (int i = 0; i < 4; i++) bit0(1'b0);
        rx0 = 1'b1;
        repeat (CPB0 / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_data0", 32'(data0), 32'd0);
        chk("midrst_valid0", 32'(valid0), 32'd0);
        chk("midrst_perr0", 32'(perr0), 32'd0);
        chk("midrst_ferr0", 32'(ferr0), 32'd0);
        chk("midrst_busy0", 32'(busy0), 32'd0);
        chk("midrst_data1", 32'(data1), 32'd0);
        rst = 1'b0;
        repeat (5 * CPB0) @(negedge clk);
        chk("midrst_idle_busy0", 32'(busy0), 32'd0);
        send0(8'h5A, 1'b1, 1'b1, 20);
        drain("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
